// File: rtl/banked_mmio_memory_pkg.sv
// Shared definitions for banked_mmio_memory: address-map derivation and FSM states.
package banked_mmio_memory_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    function automatic int addr_width(input int bank_w, input int data_w);
        return bank_w + data_w;
    endfunction

    // The IO registers occupy the very top of the address space; RAM fills everything below.
    function automatic int io_base(input int addr_w, input int n_in, input int n_out);
        return (1 << addr_w) - n_in - n_out;
    endfunction

endpackage

// File: rtl/banked_mmio_memory_port_sync.sv
// Two-flop synchroniser for the external input ports, async active-low reset.
module port_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_data,
    output logic [WIDTH-1:0] sync_data
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta      <= '0;
            sync_data <= '0;
        end else begin
            meta      <= async_data;
            sync_data <= meta;
        end
    end

endmodule

// File: rtl/banked_mmio_memory.sv
// Banked data RAM with memory-mapped input/output port registers behind the shared bus.
// Optional feature: define MMIO_AUTOINC_EN to auto-increment addr_reg after each accepted access.
module banked_mmio_memory
    import banked_mmio_memory_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BANK_W        = 2,
    parameter int NUM_IN_PORTS  = 2,
    parameter int NUM_OUT_PORTS = 2,
    parameter int PORT_W        = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_addr_write_en,
    input  logic                            in_write_en,
    input  logic                            in_read_en,
    input  logic [BANK_W-1:0]               in_bank,
    input  logic [DATA_W-1:0]               in_data,
    output logic [DATA_W-1:0]               out_data,
    output logic                            out_data_valid,
    output logic                            out_busy,
    input  logic [NUM_IN_PORTS*PORT_W-1:0]  in_port,
    output logic [NUM_OUT_PORTS*PORT_W-1:0] out_port
);

    localparam int ADDR_W   = addr_width(BANK_W, DATA_W);
    localparam int IO_BASE  = io_base(ADDR_W, NUM_IN_PORTS, NUM_OUT_PORTS);
    localparam int OUT_BASE = IO_BASE + NUM_IN_PORTS;

    state_t                          state;
    state_t                          state_next;
    logic [ADDR_W-1:0]               addr_reg;
    logic [ADDR_W-1:0]               addr_next;
    logic [NUM_IN_PORTS*PORT_W-1:0]  in_sync;
    logic [NUM_OUT_PORTS*PORT_W-1:0] out_port_reg;
    logic [DATA_W-1:0]               mem [IO_BASE];
    logic [DATA_W-1:0]               ram_q;
    logic [DATA_W-1:0]               io_q;
    logic [DATA_W-1:0]               io_rd_val;
    logic                            rd_is_ram;
    logic                            is_ram;
    logic                            idle;
    logic                            addr_acc;
    logic                            wr_acc;
    logic                            rd_acc;

    port_sync #(
        .WIDTH(NUM_IN_PORTS * PORT_W)
    ) u_port_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .async_data(in_port),
        .sync_data (in_sync)
    );

    // Every request is ignored while a read is in flight; a write wins over a same-cycle read.
    assign idle     = (state == IDLE);
    assign addr_acc = idle && in_addr_write_en;
    assign wr_acc   = idle && in_write_en;
    assign rd_acc   = idle && in_read_en && !in_write_en;
    assign is_ram   = (addr_reg < ADDR_W'(IO_BASE));

    always_comb begin
        io_rd_val = '0;
        for (int k = 0; k < NUM_IN_PORTS; k++) begin
            if (addr_reg == ADDR_W'(IO_BASE + k)) begin
                io_rd_val = DATA_W'(in_sync[k*PORT_W +: PORT_W]);
            end
        end
        for (int k = 0; k < NUM_OUT_PORTS; k++) begin
            if (addr_reg == ADDR_W'(OUT_BASE + k)) begin
                io_rd_val = DATA_W'(out_port_reg[k*PORT_W +: PORT_W]);
            end
        end
    end

    always_comb begin
        state_next = state;
        addr_next  = addr_reg;
        unique case (state)
            IDLE:    if (rd_acc) state_next = READ;
            READ:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
`ifdef MMIO_AUTOINC_EN
        if (wr_acc || rd_acc) begin
            addr_next = addr_reg + ADDR_W'(1);
        end
`endif
        // A same-cycle access already used the old address; the new one overrides any increment.
        if (addr_acc) begin
            addr_next = {in_bank, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_reg <= '0;
        end else begin
            state    <= state_next;
            addr_reg <= addr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_port_reg <= '0;
            io_q         <= '0;
            rd_is_ram    <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_OUT_PORTS; k++) begin
                if (wr_acc && addr_reg == ADDR_W'(OUT_BASE + k)) begin
                    out_port_reg[k*PORT_W +: PORT_W] <= in_data[PORT_W-1:0];
                end
            end
            if (rd_acc) begin
                io_q      <= io_rd_val;
                rd_is_ram <= is_ram;
            end
        end
    end

    // RAM contents and its read register are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc && is_ram) begin
            mem[addr_reg] <= in_data;
        end
        if (rd_acc && is_ram) begin
            ram_q <= mem[addr_reg];
        end
    end

    assign out_data_valid = (state == READ);
    assign out_busy       = (state == READ);
    assign out_data       = out_data_valid ? (rd_is_ram ? ram_q : io_q) : '0;
    assign out_port       = out_port_reg;

endmodule

// File: tb/tb_banked_mmio_memory.sv
// Scoreboard bench for banked_mmio_memory; the autoincrement scenario runs when MMIO_AUTOINC_EN is defined.
module tb_banked_mmio_memory;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_addr_write_en;
    logic       in_write_en;
    logic       in_read_en;
    logic [1:0] in_bank;
    logic [7:0] in_data;
    logic [7:0] out_data;
    logic       out_data_valid;
    logic       out_busy;
    logic [7:0] in_port;
    logic [7:0] out_port;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];

    always #5 clk = ~clk;

    banked_mmio_memory dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_addr_write_en(in_addr_write_en),
        .in_write_en     (in_write_en),
        .in_read_en      (in_read_en),
        .in_bank         (in_bank),
        .in_data         (in_data),
        .out_data        (out_data),
        .out_data_valid  (out_data_valid),
        .out_busy        (out_busy),
        .in_port         (in_port),
        .out_port        (out_port)
    );

    // Every valid cycle must match the oldest expected read result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_data_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_valid: out_data=%h with no read pending", out_data);
            end else begin
                logic [7:0] e;
                string      nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (out_data !== e) begin
                    bad++;
                    $display("[TB] FAIL %s: out_data=%h expected=%h", nm, out_data, e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [9:0] a);
        in_addr_write_en = 1'b1;
        in_bank          = a[9:8];
        in_data          = a[7:0];
        cyc();
        in_addr_write_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        in_write_en = 1'b1;
        in_data     = d;
        cyc();
        in_write_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        in_read_en = 1'b1;
        cyc();
        in_read_en = 1'b0;
        cyc();
    endtask

    // Read the current address while reloading addr_reg with a, which pins the address in every build.
    task automatic rd_keep(input logic [9:0] a, input logic [7:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        in_read_en       = 1'b1;
        in_addr_write_en = 1'b1;
        in_bank          = a[9:8];
        in_data          = a[7:0];
        cyc();
        in_read_en       = 1'b0;
        in_addr_write_en = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        total++;
        if (out_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_out_data: got=%h want=00", out_data); end
        total++;
        if (out_data_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got=%b want=0", out_data_valid); end
        total++;
        if (out_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got=%b want=0", out_busy); end
        total++;
        if (out_port !== 8'h00) begin bad++; $display("[TB] FAIL reset_out_port: got=%h want=00", out_port); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_ram_round_trip();
        set_addr(10'h235);
        wr(8'hA5);
        set_addr(10'h235);
        exp_q.push_back(8'hA5);
        name_q.push_back("ram_round_trip");
        in_read_en = 1'b1;
        cyc();
        in_read_en = 1'b0;
        total++;
        if (out_data_valid !== 1'b1) begin bad++; $display("[TB] FAIL ram_valid_rise: got=%b want=1", out_data_valid); end
        total++;
        if (out_busy !== 1'b1) begin bad++; $display("[TB] FAIL ram_busy_rise: got=%b want=1", out_busy); end
        cyc();
        total++;
        if (out_data_valid !== 1'b0) begin bad++; $display("[TB] FAIL ram_valid_one_cycle: got=%b want=0", out_data_valid); end
        total++;
        if (out_busy !== 1'b0) begin bad++; $display("[TB] FAIL ram_busy_one_cycle: got=%b want=0", out_busy); end
    endtask

    task automatic test_output_port();
        set_addr(10'h3FF);
        wr(8'h5C);
        total++;
        if (out_port[7:4] !== 4'hC) begin bad++; $display("[TB] FAIL out1_pin: got=%h want=c", out_port[7:4]); end
        total++;
        if (out_port[3:0] !== 4'h0) begin bad++; $display("[TB] FAIL out0_untouched: got=%h want=0", out_port[3:0]); end
        set_addr(10'h3FF);
        rd(8'h0C, "out1_readback");
    endtask

    task automatic test_input_sync();
        set_addr(10'h3FC);
        in_port[3:0] = 4'h9;
        cyc();
        rd_keep(10'h3FC, 8'h00, "in0_too_early");
        rd_keep(10'h3FC, 8'h09, "in0_synced");
        wr(8'hFF);
        set_addr(10'h3FC);
        rd(8'h09, "in0_write_ignored");
    endtask

    task automatic test_collisions();
        set_addr(10'h020);
        in_write_en = 1'b1;
        in_read_en  = 1'b1;
        in_data     = 8'h77;
        cyc();
        in_write_en = 1'b0;
        in_read_en  = 1'b0;
        total++;
        if (out_data_valid !== 1'b0) begin bad++; $display("[TB] FAIL rw_collision_valid: got=%b want=0", out_data_valid); end
        total++;
        if (out_busy !== 1'b0) begin bad++; $display("[TB] FAIL rw_collision_busy: got=%b want=0", out_busy); end
        set_addr(10'h020);
        rd(8'h77, "rw_collision_write_stored");

        set_addr(10'h030);
        wr(8'h10);
        set_addr(10'h020);
        exp_q.push_back(8'h77);
        name_q.push_back("read_before_ignored_requests");
        in_read_en = 1'b1;
        cyc();
        total++;
        if (out_busy !== 1'b1) begin bad++; $display("[TB] FAIL busy_during_read: got=%b want=1", out_busy); end
        in_addr_write_en = 1'b1;
        in_write_en      = 1'b1;
        in_bank          = 2'h0;
        in_data          = 8'h30;
        cyc();
        in_addr_write_en = 1'b0;
        in_write_en      = 1'b0;
        in_read_en       = 1'b0;
        total++;
        if (out_data_valid !== 1'b0) begin bad++; $display("[TB] FAIL read_during_read_dropped: got=%b want=0", out_data_valid); end
`ifndef MMIO_AUTOINC_EN
        rd(8'h77, "addr_write_during_read_ignored");
`endif
        set_addr(10'h030);
        rd(8'h10, "write_during_read_ignored");
    endtask

    task automatic test_reset_mid_read();
        set_addr(10'h235);
        in_read_en = 1'b1;
        cyc();
        in_read_en = 1'b0;
        total++;
        if (out_data_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_read_valid_before_reset: got=%b want=1", out_data_valid); end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_data_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_read_valid_async_drop: got=%b want=0", out_data_valid); end
        total++;
        if (out_busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_read_busy_async_drop: got=%b want=0", out_busy); end
        total++;
        if (out_data !== 8'h00) begin bad++; $display("[TB] FAIL mid_read_data_cleared: got=%h want=00", out_data); end
        cyc();
        rst_n = 1'b1;
        total++;
        if (out_port !== 8'h00) begin bad++; $display("[TB] FAIL out_port_after_reset: got=%h want=00", out_port); end
        cyc();
        set_addr(10'h235);
        rd(8'hA5, "ram_kept_over_reset");
    endtask

`ifdef MMIO_AUTOINC_EN
    task automatic test_autoinc();
        set_addr(10'h3FE);
        wr(8'h06);
        set_addr(10'h3FB);
        wr(8'h11);
        wr(8'h07);
        total++;
        if (out_port[3:0] !== 4'h6) begin bad++; $display("[TB] FAIL autoinc_out0_untouched: got=%h want=6", out_port[3:0]); end
        rd(8'h00, "autoinc_reaches_in1");
        rd(8'h06, "autoinc_reaches_out0");
        set_addr(10'h3FC);
        rd(8'h09, "autoinc_in0_write_ignored");
        set_addr(10'h3FB);
        rd(8'h11, "autoinc_ram_top_word");
        set_addr(10'h3FF);
        wr(8'h0A);
        wr(8'hAB);
        wr(8'hCD);
        wr(8'hEF);
        total++;
        if (out_port[7:4] !== 4'hA) begin bad++; $display("[TB] FAIL autoinc_out1_before_wrap: got=%h want=a", out_port[7:4]); end
        set_addr(10'h000);
        rd(8'hAB, "autoinc_wrap_word0");
        rd(8'hCD, "autoinc_wrap_word1");
        rd(8'hEF, "autoinc_wrap_word2");
    endtask
`else
    task automatic test_no_autoinc();
        set_addr(10'h140);
        wr(8'h11);
        wr(8'h22);
        rd(8'h22, "addr_stays_after_write");
        rd(8'h22, "addr_stays_after_read");
    endtask
`endif

    initial begin
        rst_n            = 1'b0;
        in_addr_write_en = 1'b0;
        in_write_en      = 1'b0;
        in_read_en       = 1'b0;
        in_bank          = 2'h0;
        in_data          = 8'h00;
        in_port          = 8'h00;

        test_reset();
        test_ram_round_trip();
        test_output_port();
        test_input_sync();
        test_collisions();
        test_reset_mid_read();
`ifdef MMIO_AUTOINC_EN
        test_autoinc();
`else
        test_no_autoinc();
`endif
        repeat (3) cyc();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL reads_outstanding: pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
